// File: rtl/axi4_lite_regfile_if.sv
// AXI4-Lite bus bundle for axi4_lite_regfile, plus debug taps that expose the write/read FSM states.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both high; valid holds until then.
interface axi4_lite_regfile_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_SIZE  = 32
);
    logic [ADDR_WIDTH-1:0]  write_address_i;
    logic                   write_address_valid_i;
    logic                   write_address_ready_o;
    logic [DATA_SIZE-1:0]   write_data_i;
    logic [DATA_SIZE/8-1:0] write_data_strb_i;
    logic                   write_data_valid_i;
    logic                   write_data_ready_o;
    logic [1:0]             write_response_o;
    logic                   write_response_valid_o;
    logic                   write_response_ready_i;
    logic [ADDR_WIDTH-1:0]  read_address_i;
    logic                   read_address_valid_i;
    logic                   read_address_ready_o;
    logic [DATA_SIZE-1:0]   read_data_o;
    logic [1:0]             read_data_response_o;
    logic                   read_data_valid_o;
    logic                   read_data_ready_i;
    logic                   dbg_w_state;
    logic                   dbg_r_state;

    modport slave (
        input  write_address_i, write_address_valid_i,
        input  write_data_i, write_data_strb_i, write_data_valid_i,
        input  write_response_ready_i,
        input  read_address_i, read_address_valid_i,
        input  read_data_ready_i,
        output write_address_ready_o, write_data_ready_o,
        output write_response_o, write_response_valid_o,
        output read_address_ready_o,
        output read_data_o, read_data_response_o, read_data_valid_o,
        output dbg_w_state, dbg_r_state
    );

    modport master (
        output write_address_i, write_address_valid_i,
        output write_data_i, write_data_strb_i, write_data_valid_i,
        output write_response_ready_i,
        output read_address_i, read_address_valid_i,
        output read_data_ready_i,
        input  write_address_ready_o, write_data_ready_o,
        input  write_response_o, write_response_valid_o,
        input  read_address_ready_o,
        input  read_data_o, read_data_response_o, read_data_valid_o,
        input  dbg_w_state, dbg_r_state
    );
endinterface

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave with a parametrised register file; read-only registers mirror hw_data_i.
// Optional macro AXI4_LITE_REGFILE_WRITE_PULSE_EN adds write_pulse_o (one-cycle strobe per successful write).
module axi4_lite_regfile #(
    parameter int                   ADDR_WIDTH  = 12,
    parameter int                   DATA_SIZE   = 32,
    parameter int                   DEPTH       = 16,
    parameter logic [DATA_SIZE-1:0] RESET_VALUE = '0,
    parameter logic [DEPTH-1:0]     RO_MASK     = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_clk_ni,
    axi4_lite_regfile_if.slave         bus,
    input  logic [DEPTH*DATA_SIZE-1:0] hw_data_i,
    output logic [DEPTH*DATA_SIZE-1:0] reg_data_o
`ifdef AXI4_LITE_REGFILE_WRITE_PULSE_EN
    ,
    output logic [DEPTH-1:0]           write_pulse_o
`endif
);
    localparam int NB  = DATA_SIZE / 8;
    localparam int LSB = $clog2(NB);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t              r_w_state;
    r_state_t              r_r_state;
    logic                  r_aw_full, r_w_full;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [DATA_SIZE-1:0]  r_w_data;
    logic [NB-1:0]         r_w_strb;
    logic                  r_awready, r_wready, r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_arready, r_rvalid;
    logic [DATA_SIZE-1:0]  r_rdata;
    logic [1:0]            r_rresp;
    logic [DATA_SIZE-1:0]  r_regs [DEPTH];
    logic [DEPTH-1:0]      r_write_pulse;

    logic                  w_aw_hs, w_w_hs, w_aw_full_n, w_w_full_n, w_commit;
    logic [ADDR_WIDTH-1:0] w_aw_addr_n, w_aw_idx;
    logic [DATA_SIZE-1:0]  w_w_data_n;
    logic [NB-1:0]         w_w_strb_n;
    logic                  w_aw_ro, w_wr_err;
    logic                  w_ar_hs, w_ar_in_range;
    logic [ADDR_WIDTH-1:0] w_ar_idx;
    logic [DATA_SIZE-1:0]  w_rd_data;

    // A beat arriving on the commit edge bypasses its hold so both-together commits immediately.
    always_comb begin
        w_aw_hs     = bus.write_address_valid_i & r_awready;
        w_w_hs      = bus.write_data_valid_i & r_wready;
        w_aw_full_n = r_aw_full | w_aw_hs;
        w_w_full_n  = r_w_full | w_w_hs;
        w_aw_addr_n = w_aw_hs ? bus.write_address_i : r_aw_addr;
        w_w_data_n  = w_w_hs ? bus.write_data_i : r_w_data;
        w_w_strb_n  = w_w_hs ? bus.write_data_strb_i : r_w_strb;
        w_commit    = (r_w_state == W_IDLE) && w_aw_full_n && w_w_full_n;
        w_aw_idx    = w_aw_addr_n >> LSB;
        w_aw_ro     = 1'b0;
        for (int n = 0; n < DEPTH; n++) begin
            if (w_aw_idx == ADDR_WIDTH'(n) && RO_MASK[n]) w_aw_ro = 1'b1;
        end
        w_wr_err = (w_aw_idx >= ADDR_WIDTH'(DEPTH)) || w_aw_ro;
    end

    always_comb begin
        w_ar_hs       = bus.read_address_valid_i & r_arready;
        w_ar_idx      = bus.read_address_i >> LSB;
        w_ar_in_range = w_ar_idx < ADDR_WIDTH'(DEPTH);
        w_rd_data     = '0;
        for (int n = 0; n < DEPTH; n++) begin
            if (w_ar_idx == ADDR_WIDTH'(n))
                w_rd_data = RO_MASK[n] ? hw_data_i[n*DATA_SIZE +: DATA_SIZE] : r_regs[n];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_clk_ni) begin
            r_w_state     <= W_IDLE;
            r_aw_full     <= 1'b0;
            r_w_full      <= 1'b0;
            r_aw_addr     <= '0;
            r_w_data      <= '0;
            r_w_strb      <= '0;
            r_awready     <= 1'b0;
            r_wready      <= 1'b0;
            r_bvalid      <= 1'b0;
            r_bresp       <= 2'b00;
            r_write_pulse <= '0;
            for (int n = 0; n < DEPTH; n++) r_regs[n] <= RO_MASK[n] ? '0 : RESET_VALUE;
        end else begin
            r_write_pulse <= '0;
            case (r_w_state)
                W_IDLE: begin
                    if (w_commit) begin
                        r_w_state <= W_RESP;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_err ? 2'b10 : 2'b00;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_full <= 1'b1;
                        r_w_full  <= 1'b1;
                        for (int n = 0; n < DEPTH; n++) begin
                            if (!w_wr_err && w_aw_idx == ADDR_WIDTH'(n)) begin
                                for (int k = 0; k < NB; k++) begin
                                    if (w_w_strb_n[k]) r_regs[n][8*k +: 8] <= w_w_data_n[8*k +: 8];
                                end
                                r_write_pulse[n] <= |w_w_strb_n;
                            end
                        end
                    end else begin
                        r_aw_full <= w_aw_full_n;
                        r_w_full  <= w_w_full_n;
                        r_aw_addr <= w_aw_addr_n;
                        r_w_data  <= w_w_data_n;
                        r_w_strb  <= w_w_strb_n;
                        r_awready <= !w_aw_full_n;
                        r_wready  <= !w_w_full_n;
                    end
                end
                W_RESP: begin
                    if (bus.write_response_ready_i) begin
                        r_w_state <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_bresp   <= 2'b00;
                        r_aw_full <= 1'b0;
                        r_w_full  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Read data is captured at the AR edge, so a same-edge write commit is not visible.
    always_ff @(posedge clk_i) begin
        if (!rst_clk_ni) begin
            r_r_state <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            case (r_r_state)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_r_state <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_ar_in_range ? w_rd_data : '0;
                        r_rresp   <= w_ar_in_range ? 2'b00 : 2'b10;
                    end
                end
                R_DATA: begin
                    if (bus.read_data_ready_i) begin
                        r_r_state <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        reg_data_o = '0;
        for (int n = 0; n < DEPTH; n++) reg_data_o[n*DATA_SIZE +: DATA_SIZE] = r_regs[n];
    end

`ifdef AXI4_LITE_REGFILE_WRITE_PULSE_EN
    assign write_pulse_o = r_write_pulse;
`endif

    assign bus.write_address_ready_o  = r_awready;
    assign bus.write_data_ready_o     = r_wready;
    assign bus.write_response_o       = r_bresp;
    assign bus.write_response_valid_o = r_bvalid;
    assign bus.read_address_ready_o   = r_arready;
    assign bus.read_data_o            = r_rdata;
    assign bus.read_data_response_o   = r_rresp;
    assign bus.read_data_valid_o      = r_rvalid;
    assign bus.dbg_w_state            = r_w_state;
    assign bus.dbg_r_state            = r_r_state;
endmodule
